stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run-control sequencer for the stopwatch datapath; runs on the 1 kHz system tick.
//  Debounces the front-panel buttons and drives the counter controls: enable, single-step and clear.
//  Keeps a 4-entry lap buffer and selects the value sent to the seven-segment controller.
//  Sits between the clock divider output and the counter / display controller.
// PARAMETERS
//  DB_TICKS  20  clk cycles a button must be stable before a press or release is accepted (20 ms at 1 kHz)
//  CNT_W     16  width of the counter value (4 BCD digits)
//  LAP_N      4  lap buffer depth; must be a power of 2
// PORTS
//  clk       in   1      1 kHz tick clock (clk_1K at top level)
//  rst       in   1      synchronous, active-high reset
//  start     in   1      raw start button, asynchronous, active-high
//  stop      in   1      raw stop button
//  inc       in   1      raw single-step button
//  lap       in   1      raw lap/recall button
//  clr       in   1      raw clear button
//  cnt       in   CNT_W  live counter value
//  time_en   out  1      counter enable (level)
//  step      out  1      one-cycle counter increment pulse
//  clr_o     out  1      one-cycle counter clear pulse
//  disp_val  out  CNT_W  value sent to the display
//  disp_sel  out  1      0 = live cnt, 1 = lap/recall value
//  lap_cnt   out  3      valid lap entries, 0..LAP_N
//  run_st    out  2      current state: 0 IDLE, 1 RUN, 2 LAP, 3 PAUSE
// BEHAVIOUR
//  Reset, taken on the rst clock edge:
//   - state IDLE; all outputs 0.
//   - disp_val shows cnt; lap buffer emptied.
//   - debouncers cleared to the released state.
//  Debounce, per button:
//   - 2-FF synchroniser, then stability counter.
//   - One-cycle press pulse after the input has been high DB_TICKS consecutive cycles.
//   - Re-arm only after the input has been low DB_TICKS cycles.
//   - Glitches shorter than DB_TICKS produce nothing; at most one pulse per press.
//  Timing:
//   - A press pulse in cycle N updates state and registered outputs, visible in cycle N+1.
//   - A lap capture samples cnt in cycle N.
//  Priority when pulses coincide: stop > start > lap > inc > clr; the lower-priority pulses in that cycle are dropped.
//  State transitions:
//   - IDLE:  start -> RUN; inc -> step pulse; stop, lap, clr ignored.
//   - RUN:   time_en=1; stop -> PAUSE; lap -> capture cnt, go to LAP.
//   - LAP:   time_en=1; disp_sel=1 and disp_val=newest lap.
//            lap -> capture again; start -> RUN (live display); stop -> PAUSE.
//   - PAUSE: time_en=0.
//            start -> RUN, ends recall.
//            inc -> step pulse.
//            clr -> clr_o pulse, empty buffer, go to IDLE.
//            lap -> recall mode (see lap buffer).
//   - inc ignored in RUN and LAP; clr ignored outside PAUSE.
//  Lap buffer:
//   - Circular, LAP_N entries.
//   - A write when full overwrites the oldest entry; lap_cnt saturates at LAP_N.
//  Recall, in PAUSE:
//   - First lap press shows the newest entry (disp_sel=1).
//   - Each further press steps to the next older entry, wrapping to the newest after the oldest valid one.
//   - Lap press with lap_cnt=0 is ignored; disp_sel stays 0.
//  disp_val while disp_sel=0 is cnt passed straight through, no register.
// STRUCTURE
//  Shared package/header: state encodings ST_IDLE..ST_PAUSE, the DB_TICKS default, and the button index constants.
//  Sub-module btn_debounce (sync + stability counter + press pulse), instantiated five times.
//  This module contains the FSM, lap buffer and display mux.
// TESTING
//  Run with DB_TICKS=4.
//  1. start high 2 cycles then low (glitch) -> no pulse, run_st=0.
//     start held 8 cycles -> exactly one pulse, then run_st=1, time_en=1.
//  2. RUN, cnt=16'h0123, lap press -> run_st=2, disp_sel=1, disp_val=0123 while cnt advances, lap_cnt=1.
//  3. Laps captured at cnt=1,2,3,4,5 -> lap_cnt=4.
//     stop, then 5 lap presses -> disp_val sequence 5,4,3,2,5.
//  4. RUN, start and stop pulses in the same cycle -> PAUSE, time_en=0 next cycle.
//  5. PAUSE: inc press -> step high exactly 1 cycle.
//     clr press -> clr_o 1 cycle, run_st=0, lap_cnt=0, disp_sel=0.
//  6. rst asserted mid-LAP -> next cycle all outputs 0, run_st=0, lap_cnt=0, disp_val=cnt.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants for the stopwatch run-control block: state encodings,
// the default debounce length and the button index map.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_LAP   = 2'd2,
      ST_PAUSE = 2'd3
   } run_state_t;

   // 20 ms at the 1 kHz tick
   localparam int DB_TICKS_DEF = 20;

   // Bit positions of the buttons in the packed button vectors
   localparam int BTN_START = 0;
   localparam int BTN_STOP  = 1;
   localparam int BTN_INC   = 2;
   localparam int BTN_LAP   = 3;
   localparam int BTN_CLR   = 4;
   localparam int NUM_BTN   = 5;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the front panel / counter side and the run-control
// sequencer. There is no valid/ready handshake: buttons are raw levels,
// step and clr_o are single-cycle pulses, time_en/disp_sel are levels, and
// run_st mirrors the sequencer state every cycle.
interface stopwatch_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             stop;
   logic             inc;
   logic             lap;
   logic             clr;
   logic [CNT_W-1:0] cnt;
   logic             time_en;
   logic             step;
   logic             clr_o;
   logic [CNT_W-1:0] disp_val;
   logic             disp_sel;
   logic [2:0]       lap_cnt;
   logic [1:0]       run_st;

   // Front panel and counter side
   modport master (
      output start, stop, inc, lap, clr, cnt,
      input  time_en, step, clr_o, disp_val, disp_sel, lap_cnt, run_st
   );

   // Run-control sequencer side
   modport slave (
      input  start, stop, inc, lap, clr, cnt,
      output time_en, step, clr_o, disp_val, disp_sel, lap_cnt, run_st
   );
endinterface

// File: rtl/btn_debounce.sv
// One front-panel button: two-flop synchroniser, stability counter and a
// single-cycle press pulse. The accepted level only flips after the
// synchronised input has disagreed with it for DB_TICKS consecutive cycles,
// so a press must be fully released before another pulse can be produced.
module btn_debounce
   import stopwatch_ctrl_pkg::*;
#(
   parameter int DB_TICKS = DB_TICKS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   localparam int CW = $clog2(DB_TICKS + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] stab_cnt;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Count disagreeing cycles; flip the accepted level and pulse on a press
   always_ff @(posedge clk) begin
      if (rst) begin
         level    <= 1'b0;
         stab_cnt <= '0;
         press    <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync2 == level) begin
            stab_cnt <= '0;
         end else if (stab_cnt == CW'(DB_TICKS - 1)) begin
            level    <= sync2;
            stab_cnt <= '0;
            press    <= sync2;
         end else begin
            stab_cnt <= stab_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: debounces five buttons, drives counter
// enable / step / clear, keeps a circular lap buffer with recall, and
// selects the value shown on the seven-segment display.
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int DB_TICKS = DB_TICKS_DEF,
   parameter int CNT_W    = 16,
   parameter int LAP_N    = 4
) (
   input  logic           clk,
   input  logic           rst,
   stopwatch_ctrl_if.slave bus
);
   localparam int PW = (LAP_N > 1) ? $clog2(LAP_N) : 1;

   logic [NUM_BTN-1:0] raw;
   logic [NUM_BTN-1:0] press;

   run_state_t state;
   run_state_t state_nxt;

   logic             w_stop, w_start, w_lap, w_inc, w_clr;
   logic             do_cap, do_step, do_clr, rc_adv;
   logic [CNT_W-1:0] mem [LAP_N];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_off;
   logic [PW-1:0]    rd_idx;
   logic [2:0]       lap_cnt;
   logic             recall;
   logic             step_q;
   logic             clr_q;
   logic             disp_sel;

   assign raw[BTN_START] = bus.start;
   assign raw[BTN_STOP]  = bus.stop;
   assign raw[BTN_INC]   = bus.inc;
   assign raw[BTN_LAP]   = bus.lap;
   assign raw[BTN_CLR]   = bus.clr;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
      btn_debounce #(.DB_TICKS(DB_TICKS)) u_db (
         .clk   (clk),
         .rst   (rst),
         .btn   (raw[gi]),
         .press (press[gi])
      );
   end

   // Only the highest-priority pulse of a cycle survives: stop > start > lap > inc > clr
   assign w_stop  = press[BTN_STOP];
   assign w_start = press[BTN_START] & ~w_stop;
   assign w_lap   = press[BTN_LAP]   & ~w_stop & ~press[BTN_START];
   assign w_inc   = press[BTN_INC]   & ~w_stop & ~press[BTN_START] & ~press[BTN_LAP];
   assign w_clr   = press[BTN_CLR]   & ~w_stop & ~press[BTN_START] & ~press[BTN_LAP]
                                     & ~press[BTN_INC];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state and the actions requested by the winning pulse
   always_comb begin
      state_nxt = state;
      do_cap    = 1'b0;
      do_step   = 1'b0;
      do_clr    = 1'b0;
      rc_adv    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (w_start)    state_nxt = ST_RUN;
            else if (w_inc) do_step   = 1'b1;
         end
         ST_RUN: begin
            if (w_stop) begin
               state_nxt = ST_PAUSE;
            end else if (w_lap) begin
               do_cap    = 1'b1;
               state_nxt = ST_LAP;
            end
         end
         ST_LAP: begin
            if (w_stop)       state_nxt = ST_PAUSE;
            else if (w_start) state_nxt = ST_RUN;
            else if (w_lap)   do_cap    = 1'b1;
         end
         ST_PAUSE: begin
            if (w_start) begin
               state_nxt = ST_RUN;
            end else if (w_lap) begin
               rc_adv = (lap_cnt != 3'd0);
            end else if (w_inc) begin
               do_step = 1'b1;
            end else if (w_clr) begin
               do_clr    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Lap bookkeeping, recall position and the registered counter pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         lap_cnt <= 3'd0;
         recall  <= 1'b0;
         rd_off  <= '0;
         step_q  <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         step_q <= do_step;
         clr_q  <= do_clr;
         if (do_cap) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (lap_cnt != 3'(LAP_N)) lap_cnt <= lap_cnt + 3'd1;
         end
         if (do_clr) begin
            wr_ptr  <= '0;
            lap_cnt <= 3'd0;
         end
         // Recall lives only in PAUSE; offset 0 is the newest entry
         if (state_nxt != ST_PAUSE) begin
            recall <= 1'b0;
            rd_off <= '0;
         end else if (rc_adv) begin
            if (!recall) begin
               recall <= 1'b1;
               rd_off <= '0;
            end else if ((3'(rd_off) + 3'd1) == lap_cnt) begin
               rd_off <= '0;
            end else begin
               rd_off <= rd_off + PW'(1);
            end
         end
      end
   end

   // Lap storage; contents are only shown once written, so no reset needed
   always_ff @(posedge clk) begin
      if (do_cap && !rst) mem[wr_ptr] <= bus.cnt;
   end

   assign rd_idx   = wr_ptr - PW'(1) - rd_off;
   assign disp_sel = (state == ST_LAP) || ((state == ST_PAUSE) && recall);

   assign bus.time_en  = (state == ST_RUN) || (state == ST_LAP);
   assign bus.step     = step_q;
   assign bus.clr_o    = clr_q;
   assign bus.disp_sel = disp_sel;
   assign bus.disp_val = disp_sel ? mem[rd_idx] : bus.cnt;
   assign bus.lap_cnt  = lap_cnt;
   assign bus.run_st   = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;
   import stopwatch_ctrl_pkg::*;

   localparam int CNT_W = 16;
   localparam logic [4:0] M_START = 5'b00001;
   localparam logic [4:0] M_STOP  = 5'b00010;
   localparam logic [4:0] M_INC   = 5'b00100;
   localparam logic [4:0] M_LAP   = 5'b01000;
   localparam logic [4:0] M_CLR   = 5'b10000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   step_seen = 0;
   int   clr_seen = 0;

   stopwatch_ctrl_if #(.CNT_W(CNT_W)) bus ();

   stopwatch_ctrl #(.DB_TICKS(4), .CNT_W(CNT_W), .LAP_N(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   always #5 clk = ~clk;

   // Advance one cycle; sample 1 time unit after the edge and count pulses
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.step === 1'b1)  step_seen++;
      if (bus.clr_o === 1'b1) clr_seen++;
   endtask

   task automatic set_btn(input logic [4:0] m);
      bus.start = m[BTN_START];
      bus.stop  = m[BTN_STOP];
      bus.inc   = m[BTN_INC];
      bus.lap   = m[BTN_LAP];
      bus.clr   = m[BTN_CLR];
   endtask

   // Hold buttons long enough to be accepted, then release long enough to re-arm
   task automatic press(input logic [4:0] m);
      step_seen = 0;
      clr_seen  = 0;
      set_btn(m);
      repeat (8) tick();
      set_btn(5'b0);
      repeat (8) tick();
   endtask

   task automatic test_reset();
      set_btn(5'b0);
      bus.cnt = 16'h0055;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++;
      if (bus.run_st !== 2'd0) begin errors++; $display("FAIL reset_run_st: got %0d expected 0", bus.run_st); end
      checks++;
      if ({bus.time_en, bus.step, bus.clr_o, bus.disp_sel} !== 4'b0) begin
         errors++; $display("FAIL reset_outs: got %b expected 0000", {bus.time_en, bus.step, bus.clr_o, bus.disp_sel});
      end
      checks++;
      if (bus.lap_cnt !== 3'd0) begin errors++; $display("FAIL reset_lap_cnt: got %0d expected 0", bus.lap_cnt); end
      checks++;
      if (bus.disp_val !== 16'h0055) begin errors++; $display("FAIL reset_disp_val: got %h expected 0055", bus.disp_val); end
   endtask

   task automatic test_debounce();
      // 2-cycle glitch must be swallowed
      bus.start = 1'b1;
      repeat (2) tick();
      bus.start = 1'b0;
      repeat (10) tick();
      checks++;
      if (bus.run_st !== 2'd0) begin errors++; $display("FAIL glitch_run_st: got %0d expected 0", bus.run_st); end
      // A long inc press in IDLE gives exactly one step pulse
      set_btn(M_INC);
      step_seen = 0;
      repeat (14) tick();
      set_btn(5'b0);
      repeat (8) tick();
      checks++;
      if (step_seen != 1) begin errors++; $display("FAIL idle_inc_pulses: got %0d expected 1", step_seen); end
      press(M_START);
      checks++;
      if (bus.run_st !== 2'd1) begin errors++; $display("FAIL start_run_st: got %0d expected 1", bus.run_st); end
      checks++;
      if (bus.time_en !== 1'b1) begin errors++; $display("FAIL start_time_en: got %b expected 1", bus.time_en); end
   endtask

   task automatic test_lap_capture();
      bus.cnt = 16'h0123;
      press(M_LAP);
      checks++;
      if (bus.run_st !== 2'd2) begin errors++; $display("FAIL lap_run_st: got %0d expected 2", bus.run_st); end
      checks++;
      if (bus.lap_cnt !== 3'd1) begin errors++; $display("FAIL lap_lap_cnt: got %0d expected 1", bus.lap_cnt); end
      for (int i = 0; i < 3; i++) begin
         bus.cnt = 16'h0124 + 16'(i);
         tick();
         checks++;
         if (bus.disp_sel !== 1'b1 || bus.disp_val !== 16'h0123) begin
            errors++; $display("FAIL lap_hold: got sel=%b val=%h expected sel=1 val=0123", bus.disp_sel, bus.disp_val);
         end
      end
   endtask

   task automatic test_lap_buffer();
      logic [15:0] exp_seq [5];
      exp_seq = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd5};
      for (int v = 1; v <= 5; v++) begin
         bus.cnt = 16'(v);
         press(M_LAP);
         bus.cnt = 16'h0777;
         tick();
         checks++;
         if (bus.disp_val !== 16'(v)) begin errors++; $display("FAIL lap_newest_%0d: got %h expected %h", v, bus.disp_val, 16'(v)); end
      end
      checks++;
      if (bus.lap_cnt !== 3'd4) begin errors++; $display("FAIL lap_saturate: got %0d expected 4", bus.lap_cnt); end
      bus.cnt = 16'h0999;
      press(M_STOP);
      checks++;
      if (bus.run_st !== 2'd3 || bus.disp_sel !== 1'b0 || bus.disp_val !== 16'h0999) begin
         errors++; $display("FAIL stop_to_pause: got st=%0d sel=%b val=%h expected st=3 sel=0 val=0999",
                             bus.run_st, bus.disp_sel, bus.disp_val);
      end
      for (int i = 0; i < 5; i++) begin
         press(M_LAP);
         checks++;
         if (bus.disp_sel !== 1'b1 || bus.disp_val !== exp_seq[i]) begin
            errors++; $display("FAIL recall_%0d: got sel=%b val=%h expected sel=1 val=%h",
                                i, bus.disp_sel, bus.disp_val, exp_seq[i]);
         end
      end
   endtask

   task automatic test_priority();
      press(M_START);
      checks++;
      if (bus.run_st !== 2'd1 || bus.disp_sel !== 1'b0 || bus.disp_val !== 16'h0999) begin
         errors++; $display("FAIL resume: got st=%0d sel=%b val=%h expected st=1 sel=0 val=0999",
                             bus.run_st, bus.disp_sel, bus.disp_val);
      end
      press(M_START | M_STOP);
      checks++;
      if (bus.run_st !== 2'd3 || bus.time_en !== 1'b0) begin
         errors++; $display("FAIL start_stop_prio: got st=%0d en=%b expected st=3 en=0", bus.run_st, bus.time_en);
      end
   endtask

   task automatic test_step_clear();
      press(M_INC);
      checks++;
      if (step_seen != 1 || bus.run_st !== 2'd3) begin
         errors++; $display("FAIL pause_step: got pulses=%0d st=%0d expected pulses=1 st=3", step_seen, bus.run_st);
      end
      press(M_CLR);
      checks++;
      if (clr_seen != 1) begin errors++; $display("FAIL clr_pulse: got %0d expected 1", clr_seen); end
      checks++;
      if (bus.run_st !== 2'd0 || bus.lap_cnt !== 3'd0 || bus.disp_sel !== 1'b0) begin
         errors++; $display("FAIL clr_state: got st=%0d laps=%0d sel=%b expected st=0 laps=0 sel=0",
                             bus.run_st, bus.lap_cnt, bus.disp_sel);
      end
   endtask

   task automatic test_reset_mid_lap();
      press(M_START);
      bus.cnt = 16'h0042;
      press(M_LAP);
      checks++;
      if (bus.run_st !== 2'd2) begin errors++; $display("FAIL pre_rst_lap: got %0d expected 2", bus.run_st); end
      bus.cnt = 16'h4321;
      rst = 1'b1;
      tick();
      checks++;
      if (bus.run_st !== 2'd0 || bus.lap_cnt !== 3'd0 ||
          {bus.time_en, bus.step, bus.clr_o, bus.disp_sel} !== 4'b0 || bus.disp_val !== 16'h4321) begin
         errors++; $display("FAIL rst_mid_lap: got st=%0d laps=%0d outs=%b val=%h expected st=0 laps=0 outs=0000 val=4321",
                             bus.run_st, bus.lap_cnt, {bus.time_en, bus.step, bus.clr_o, bus.disp_sel}, bus.disp_val);
      end
      rst = 1'b0;
      tick();
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_debounce();
      test_lap_capture();
      test_lap_buffer();
      test_priority();
      test_step_clear();
      test_reset_mid_lap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
